core_regfile_mp: RTL and testbench

- Parametrised multi-port integer register file for the next-generation core. Configurable read and write port counts let a dual-issue pipeline share one register array.
- Adds same-cycle write-to-read bypass.
- Adds a per-register busy scoreboard: set when an instruction issues, cleared at writeback. The decode stage uses it to detect hazards.
- Sits between decode/issue (read ports, scoreboard set) and writeback (write ports).

---
 rtl/core_regfile_mp_if.sv | 28 ++
 rtl/core_regfile_mp.sv | 107 ++++++++++
 tb/tb_core_regfile_mp.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/core_regfile_mp_if.sv
// Bundle of read, write and scoreboard signals between issue/writeback and the register file.
// The master side is the pipeline; the slave side is the register file.
interface core_regfile_mp_if #(
  parameter int DATA_W = 64,
  parameter int IDX_W  = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);
  logic [NUM_RD*IDX_W-1:0]  rd_idx;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*IDX_W-1:0]  wr_idx;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     sb_set_en;
  logic [IDX_W-1:0]         sb_set_idx;
  logic                     sb_flush;

  modport master (
    output rd_idx, wr_en, wr_idx, wr_data, sb_set_en, sb_set_idx, sb_flush,
    input  rd_data, rd_busy
  );

  modport slave (
    input  rd_idx, wr_en, wr_idx, wr_data, sb_set_en, sb_set_idx, sb_flush,
    output rd_data, rd_busy
  );
endinterface

// File: rtl/core_regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass and a per-register
// busy scoreboard used by decode for hazard detection. Register 0 is hardwired to zero.
module core_regfile_mp #(
  parameter int DATA_W = 64,
  parameter int IDX_W  = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int BYPASS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  core_regfile_mp_if.slave     i_bus
);
  localparam int DEPTH = 1 << IDX_W;

  logic [DATA_W-1:0] w_regs [DEPTH];
  logic              w_busy [DEPTH];
  logic [DATA_W-1:0] w_rd_data [NUM_RD];
  logic              w_rd_busy [NUM_RD];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign w_regs[gi] = '0;
        assign w_busy[gi] = 1'b0;
      end else begin : g_live
        logic [DATA_W-1:0] r_data;
        logic              r_busy;
        logic              w_hit;
        logic [DATA_W-1:0] w_wdata;

        // Later ports overwrite earlier matches, so the highest-numbered writer wins.
        always_comb begin
          w_hit   = 1'b0;
          w_wdata = '0;
          for (int w = 0; w < NUM_WR; w++) begin
            if (i_bus.wr_en[w] && (i_bus.wr_idx[w*IDX_W +: IDX_W] == IDX_W'(gi))) begin
              w_hit   = 1'b1;
              w_wdata = i_bus.wr_data[w*DATA_W +: DATA_W];
            end
          end
        end

        always_ff @(posedge clk) begin
          if (!rst_n) begin
            r_data <= '0;
          end else if (w_hit) begin
            r_data <= w_wdata;
          end
        end

        // A new issue supersedes an older producer's writeback to the same register.
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            r_busy <= 1'b0;
          end else if (i_bus.sb_flush) begin
            r_busy <= 1'b0;
          end else if (i_bus.sb_set_en && (i_bus.sb_set_idx == IDX_W'(gi))) begin
            r_busy <= 1'b1;
          end else if (w_hit) begin
            r_busy <= 1'b0;
          end
        end

        assign w_regs[gi] = r_data;
        assign w_busy[gi] = r_busy;
      end
    end

    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [IDX_W-1:0]  w_idx;
      logic [DATA_W-1:0] w_data;
      logic              w_bsy;

      always_comb begin
        w_idx  = i_bus.rd_idx[gi*IDX_W +: IDX_W];
        w_data = w_regs[w_idx];
        w_bsy  = w_busy[w_idx];
        if (BYPASS != 0) begin
          for (int w = 0; w < NUM_WR; w++) begin
            if (i_bus.wr_en[w] && (i_bus.wr_idx[w*IDX_W +: IDX_W] == w_idx)) begin
              w_data = i_bus.wr_data[w*DATA_W +: DATA_W];
              w_bsy  = 1'b0;
            end
          end
        end
        if (w_idx == '0) begin
          w_data = '0;
          w_bsy  = 1'b0;
        end
      end

      assign w_rd_data[gi] = w_data;
      assign w_rd_busy[gi] = w_bsy;
    end
  endgenerate

  always_comb begin
    i_bus.rd_data = '0;
    i_bus.rd_busy = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      i_bus.rd_data[p*DATA_W +: DATA_W] = w_rd_data[p];
      i_bus.rd_busy[p]                  = w_rd_busy[p];
    end
  end
endmodule

// File: tb/tb_core_regfile_mp.sv
// Drives one stimulus stream into a bypassing and a non-bypassing register file;
// a monitor pops hand-computed expectations from a scoreboard queue and compares.
module tb_core_regfile_mp;
  localparam int DW = 64;
  localparam int IW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2*IW-1:0] rd_idx;
  logic [1:0]      wr_en;
  logic [2*IW-1:0] wr_idx;
  logic [2*DW-1:0] wr_data;
  logic            sb_set_en;
  logic [IW-1:0]   sb_set_idx;
  logic            sb_flush;

  core_regfile_mp_if #(.DATA_W(DW), .IDX_W(IW), .NUM_RD(2), .NUM_WR(2)) bus1 ();
  core_regfile_mp_if #(.DATA_W(DW), .IDX_W(IW), .NUM_RD(2), .NUM_WR(2)) bus0 ();

  assign bus1.rd_idx = rd_idx;     assign bus0.rd_idx = rd_idx;
  assign bus1.wr_en = wr_en;       assign bus0.wr_en = wr_en;
  assign bus1.wr_idx = wr_idx;     assign bus0.wr_idx = wr_idx;
  assign bus1.wr_data = wr_data;   assign bus0.wr_data = wr_data;
  assign bus1.sb_set_en = sb_set_en;   assign bus0.sb_set_en = sb_set_en;
  assign bus1.sb_set_idx = sb_set_idx; assign bus0.sb_set_idx = sb_set_idx;
  assign bus1.sb_flush = sb_flush; assign bus0.sb_flush = sb_flush;

  core_regfile_mp #(.DATA_W(DW), .IDX_W(IW), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)) dut_byp (
    .clk(clk), .rst_n(rst_n), .i_bus(bus1.slave)
  );
  core_regfile_mp #(.DATA_W(DW), .IDX_W(IW), .NUM_RD(2), .NUM_WR(2), .BYPASS(0)) dut_nobyp (
    .clk(clk), .rst_n(rst_n), .i_bus(bus0.slave)
  );

  typedef struct {
    string       nm;
    int          dut;   // 0 = bypassing instance, 1 = non-bypassing instance
    int          port;
    logic [63:0] d;
    logic        b;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic idle();
    rst_n      = 1'b1;
    wr_en      = '0;
    wr_idx     = '0;
    wr_data    = '0;
    sb_set_en  = 1'b0;
    sb_set_idx = '0;
    sb_flush   = 1'b0;
  endtask

  task automatic rd(input int p, input int idx);
    rd_idx[p*IW +: IW] = idx[4:0];
  endtask

  task automatic wr(input int w, input int idx, input logic [63:0] d);
    wr_en[w]             = 1'b1;
    wr_idx[w*IW +: IW]   = idx[4:0];
    wr_data[w*DW +: DW]  = d;
  endtask

  task automatic sbset(input int idx);
    sb_set_en  = 1'b1;
    sb_set_idx = idx[4:0];
  endtask

  // Expectation for both instances: (d1,b1) bypassing, (d0,b0) non-bypassing.
  task automatic exp2(input string nm, input int port,
                      input logic [63:0] d1, input logic b1,
                      input logic [63:0] d0, input logic b0);
    exp_t e;
    e.nm = nm; e.port = port;
    e.dut = 0; e.d = d1; e.b = b1; sbq.push_back(e);
    e.dut = 1; e.d = d0; e.b = b0; sbq.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
    idle();
  endtask

  // Monitor: outputs are combinational, so sample mid-low-phase after the driver settles.
  initial begin : monitor
    exp_t        e;
    logic [63:0] ad;
    logic        ab;
    forever begin
      @(negedge clk);
      #3;
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        if (e.dut == 0) begin
          ad = bus1.rd_data[e.port*DW +: DW];
          ab = bus1.rd_busy[e.port];
        end else begin
          ad = bus0.rd_data[e.port*DW +: DW];
          ab = bus0.rd_busy[e.port];
        end
        n_vec++;
        if (ad !== e.d || ab !== e.b) begin
          n_err++;
          $display("FAIL %s byp=%0d port%0d: got data=%h busy=%b, want data=%h busy=%b",
                   e.nm, 1 - e.dut, e.port, ad, ab, e.d, e.b);
        end else begin
          $display("ok   %s byp=%0d port%0d: data=%h busy=%b", e.nm, 1 - e.dut, e.port, ad, ab);
        end
      end
    end
  end

  initial begin : driver
    idle();
    rst_n  = 1'b0;
    rd_idx = '0;
    repeat (2) @(negedge clk);

    step(); rd(0, 5); rd(1, 6);
    exp2("reset_x5", 0, 64'h0, 1'b0, 64'h0, 1'b0);
    exp2("reset_x6", 1, 64'h0, 1'b0, 64'h0, 1'b0);

    // Dual write; same-cycle reads forward only on the bypassing instance.
    step(); rd(0, 5); rd(1, 6);
    wr(0, 5, 64'hDEAD_BEEF_0000_0001); wr(1, 6, 64'h1234);
    exp2("wr_fwd_x5", 0, 64'hDEAD_BEEF_0000_0001, 1'b0, 64'h0, 1'b0);
    exp2("wr_fwd_x6", 1, 64'h1234, 1'b0, 64'h0, 1'b0);

    step(); rd(0, 5); rd(1, 6);
    wr(0, 0, 64'hFFFF); wr(1, 7, 64'h77);
    exp2("rd_x5", 0, 64'hDEAD_BEEF_0000_0001, 1'b0, 64'hDEAD_BEEF_0000_0001, 1'b0);
    exp2("rd_x6", 1, 64'h1234, 1'b0, 64'h1234, 1'b0);

    step(); rd(0, 0); rd(1, 7);
    exp2("x0_zero", 0, 64'h0, 1'b0, 64'h0, 1'b0);
    exp2("rd_x7_pre", 1, 64'h77, 1'b0, 64'h77, 1'b0);

    step(); rd(0, 7); rd(1, 0);
    wr(0, 7, 64'hAA); wr(1, 7, 64'hBB);
    exp2("collide_fwd", 0, 64'hBB, 1'b0, 64'h77, 1'b0);

    step(); rd(0, 7); rd(1, 0);
    exp2("collide_store", 0, 64'hBB, 1'b0, 64'hBB, 1'b0);

    // Scoreboard set, then writeback clears busy.
    step(); rd(0, 9); rd(1, 0); sbset(9);
    exp2("sb_same_cyc", 0, 64'h0, 1'b0, 64'h0, 1'b0);

    step(); rd(0, 9);
    exp2("sb_busy_x9", 0, 64'h0, 1'b1, 64'h0, 1'b1);

    step(); rd(0, 9); wr(0, 9, 64'h55);
    exp2("wb_x9_same", 0, 64'h55, 1'b0, 64'h0, 1'b1);

    step(); rd(0, 9);
    exp2("wb_x9_after", 0, 64'h55, 1'b0, 64'h55, 1'b0);

    // Same-cycle set beats writeback; flush beats set.
    step(); rd(1, 3); sbset(3);
    step(); rd(1, 3); sbset(3); wr(1, 3, 64'h33);
    exp2("prio_same", 1, 64'h33, 1'b0, 64'h0, 1'b1);

    step(); rd(0, 4); rd(1, 3); sb_flush = 1'b1; sbset(4);
    exp2("prio_x3_busy", 1, 64'h33, 1'b1, 64'h33, 1'b1);
    exp2("flush_x4_pre", 0, 64'h0, 1'b0, 64'h0, 1'b0);

    step(); rd(0, 4); rd(1, 3);
    exp2("flush_x4", 0, 64'h0, 1'b0, 64'h0, 1'b0);
    exp2("flush_x3", 1, 64'h33, 1'b0, 64'h33, 1'b0);

    step(); rd(0, 1); rd(1, 0); sbset(0);
    step(); rd(0, 1); rd(1, 0);
    exp2("sb_x0_ign", 1, 64'h0, 1'b0, 64'h0, 1'b0);

    // Reset arriving with busy bits set and a write pending.
    step(); sbset(10);
    step(); sbset(11);
    step(); rd(0, 10); rd(1, 11); rst_n = 1'b0; wr(0, 10, 64'hAB);
    exp2("rst_mid_x10", 0, 64'hAB, 1'b0, 64'h0, 1'b1);
    exp2("rst_mid_x11", 1, 64'h0, 1'b1, 64'h0, 1'b1);

    step(); rd(0, 10); rd(1, 11);
    exp2("post_rst_x10", 0, 64'h0, 1'b0, 64'h0, 1'b0);
    exp2("post_rst_x11", 1, 64'h0, 1'b0, 64'h0, 1'b0);

    for (int i = 0; i < 32; i++) begin
      step(); rd(0, i); rd(1, 31 - i);
      exp2($sformatf("sweep_p0_x%0d", i), 0, 64'h0, 1'b0, 64'h0, 1'b0);
      exp2($sformatf("sweep_p1_x%0d", 31 - i), 1, 64'h0, 1'b0, 64'h0, 1'b0);
    end

    step();
    repeat (4) @(negedge clk);
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
